guarded_mem_arbiter: RTL and testbench

Parametrised, multi-requester successor to the single-port deputy memory. NUM_CH requesters share one on-chip memory through a round-robin arbiter. Every access is checked against a per-region, per-channel read/write permission table, using the identity of the channel that issued it. No access is ever performed on another channel's behalf, and there is no internal write path. The block sits between bus-facing requesters and local scratch RAM.

---
 rtl/gm_pkg.sv | 40 ++++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/guarded_mem_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_guarded_mem_arbiter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gm_pkg.sv
// gm_pkg
// Shared types and constants for the guarded memory arbiter.
//   state_t       : request-processing FSM states (IDLE, CHECK, ACCESS, RESP)
//   OP_READ/WRITE : encoding of the per-channel req_we bit
//   perm_entry_t  : one permission-table row, sized for the largest channel count
//   makeEntry     : builds a table row from read/write masks
package gm_pkg;

    localparam int MAX_CH   = 8;
    localparam int MAX_CH_W = $clog2(MAX_CH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // Masks are stored at MAX_CH width so the row layout does not depend on
    // the instance's NUM_CH; bits above NUM_CH are always zero.
    typedef struct packed {
        logic [MAX_CH-1:0] rdMask;
        logic [MAX_CH-1:0] wrMask;
    } perm_entry_t;

    // Out of reset only channel 0 may read or write any region.
    localparam perm_entry_t PERM_RESET = '{rdMask: 8'h01, wrMask: 8'h01};

    function automatic perm_entry_t makeEntry(input logic [MAX_CH-1:0] rd,
                                              input logic [MAX_CH-1:0] wr);
        perm_entry_t e;
        e.rdMask = rd;
        e.wrMask = wr;
        return e;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter. The search starts at the channel after i_lastGrant and
// wraps modulo NUM_CH, so the last winner has lowest priority.
// Ports:
//   i_req       : per-channel request bits
//   i_lastGrant : index of the previous winner
//   i_enable    : when low no grant is issued
//   o_grant     : one-hot grant (all zero if disabled or no request)
//   o_grantIdx  : encoded index of the granted channel (0 when none)
module rr_arbiter
    import gm_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
)
(
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_lastGrant,
    input  logic              i_enable,
    output logic [NUM_CH-1:0] o_grant,
    output logic [CH_W-1:0]   o_grantIdx
);

    logic [CH_W-1:0] w_cand;
    logic            w_found;

    // Walk the channels in priority order starting one past the last winner;
    // the first requester found takes the grant.
    always_comb begin
        o_grant    = '0;
        o_grantIdx = '0;
        w_found    = 1'b0;
        w_cand     = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_cand = CH_W'((int'(i_lastGrant) + k) % NUM_CH);
            if (i_enable && !w_found && i_req[w_cand]) begin
                o_grant[w_cand] = 1'b1;
                o_grantIdx      = w_cand;
                w_found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/guarded_mem_arbiter.sv
// guarded_mem_arbiter
// NUM_CH requesters share one scratch RAM through a round-robin arbiter. Each
// access is checked against a per-region, per-channel read/write permission
// table using the issuing channel's own identity. One access every 4 cycles.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   req_valid/ready     : per-channel handshake, ready is a one-hot grant
//   req_we/addr/wdata   : per-channel operation, packed by channel
//   resp_valid/ch/rdata/err : one-cycle registered response, zero otherwise
//   cfg_we/region/rd_mask/wr_mask : permission-table write port
//   deny_count          : saturating count of denied accesses
//   busy                : FSM is processing an access
module guarded_mem_arbiter
    import gm_pkg::*;
#(
    parameter  int DATA_WIDTH  = 32,
    parameter  int ADDR_WIDTH  = 8,
    parameter  int NUM_CH      = 4,
    parameter  int REGION_BITS = 2,
    localparam int CH_W        = $clog2(NUM_CH),
    localparam int NR          = 2 ** REGION_BITS
)
(
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_CH-1:0]            req_valid,
    output logic [NUM_CH-1:0]            req_ready,
    input  logic [NUM_CH-1:0]            req_we,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] req_wdata,
    output logic                         resp_valid,
    output logic [CH_W-1:0]              resp_ch,
    output logic [DATA_WIDTH-1:0]        resp_rdata,
    output logic                         resp_err,
    input  logic                         cfg_we,
    input  logic [REGION_BITS-1:0]       cfg_region,
    input  logic [NUM_CH-1:0]            cfg_rd_mask,
    input  logic [NUM_CH-1:0]            cfg_wr_mask,
    output logic [15:0]                  deny_count,
    output logic                         busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    state_t                  r_state;
    state_t                  w_nextState;

    logic [CH_W-1:0]         r_lastGrant;
    logic [CH_W-1:0]         r_ch;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_allowed;

    perm_entry_t             r_table [NR];
    logic [DATA_WIDTH-1:0]   r_mem   [DEPTH];

    logic [15:0]             r_denyCount;
    logic                    r_respValid;
    logic [CH_W-1:0]         r_respCh;
    logic [DATA_WIDTH-1:0]   r_respRdata;
    logic                    r_respErr;

    logic [NUM_CH-1:0]       w_grant;
    logic [CH_W-1:0]         w_grantIdx;
    logic                    w_arbEnable;
    logic                    w_handshake;
    logic [REGION_BITS-1:0]  w_region;
    logic                    w_perm;
    logic [ADDR_WIDTH-1:0]   w_addrArr  [NUM_CH];
    logic [DATA_WIDTH-1:0]   w_wdataArr [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign w_addrArr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdataArr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Grants are only offered while idle; holding them off during reset keeps
    // req_ready low even if requesters are already asserting valid.
    assign w_arbEnable = (r_state == IDLE) && reset_n;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arbiter (
        .i_req       (req_valid),
        .i_lastGrant (r_lastGrant),
        .i_enable    (w_arbEnable),
        .o_grant     (w_grant),
        .o_grantIdx  (w_grantIdx)
    );

    assign req_ready   = w_grant;
    assign w_handshake = |(req_valid & w_grant);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Fixed four-step sequence once a request is accepted.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_handshake) w_nextState = CHECK;
            CHECK:   w_nextState = ACCESS;
            ACCESS:  w_nextState = RESP;
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Capture the winner's request. Everything downstream uses only these
    // latched fields, so no other channel's address can reach the memory.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lastGrant <= CH_W'(NUM_CH - 1);
            r_ch        <= '0;
            r_we        <= OP_READ;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else if (r_state == IDLE && w_handshake) begin
            r_lastGrant <= w_grantIdx;
            r_ch        <= w_grantIdx;
            r_we        <= req_we[w_grantIdx];
            r_addr      <= w_addrArr[w_grantIdx];
            r_wdata     <= w_wdataArr[w_grantIdx];
        end
    end

    // Permission table. A cfg write on the CHECK edge lands after the lookup
    // below has sampled the old row, so it only affects later accesses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NR; i++) begin
                r_table[i] <= PERM_RESET;
            end
        end else if (cfg_we) begin
            r_table[cfg_region] <= makeEntry(MAX_CH'(cfg_rd_mask), MAX_CH'(cfg_wr_mask));
        end
    end

    assign w_region = r_addr[ADDR_WIDTH-1 -: REGION_BITS];
    assign w_perm   = (r_we == OP_WRITE) ? r_table[w_region].wrMask[MAX_CH_W'(r_ch)]
                                         : r_table[w_region].rdMask[MAX_CH_W'(r_ch)];

    // Permission decision, taken once in CHECK and held through ACCESS.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_allowed <= 1'b0;
        end else if (r_state == CHECK) begin
            r_allowed <= w_perm;
        end
    end

    // Memory array, written only on an allowed write in ACCESS. Contents are
    // deliberately not reset.
    always_ff @(posedge clk) begin
        if (r_state == ACCESS && r_allowed && r_we == OP_WRITE) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    // Response registers and deny counter, all updated on the ACCESS edge so
    // the response is visible exactly while the FSM sits in RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_respValid <= 1'b0;
            r_respCh    <= '0;
            r_respRdata <= '0;
            r_respErr   <= 1'b0;
            r_denyCount <= '0;
        end else begin
            r_respValid <= 1'b0;
            r_respCh    <= '0;
            r_respRdata <= '0;
            r_respErr   <= 1'b0;
            if (r_state == ACCESS) begin
                r_respValid <= 1'b1;
                r_respCh    <= r_ch;
                r_respErr   <= !r_allowed;
                if (r_allowed && r_we == OP_READ) begin
                    r_respRdata <= r_mem[r_addr];
                end
                if (!r_allowed && r_denyCount != 16'hFFFF) begin
                    r_denyCount <= r_denyCount + 16'd1;
                end
            end
        end
    end

    assign resp_valid = r_respValid;
    assign resp_ch    = r_respCh;
    assign resp_rdata = r_respRdata;
    assign resp_err   = r_respErr;
    assign deny_count = r_denyCount;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_guarded_mem_arbiter.sv
// tb_guarded_mem_arbiter
// Self-checking bench for guarded_mem_arbiter (4 channels, 8-bit addresses,
// 4 regions). A transaction-level model holds memory, permission table, deny
// count and the round-robin pointer as plain arrays and integers.
module tb_guarded_mem_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int NCH = 4;
    localparam int RB  = 2;
    localparam int CHW = 2;
    localparam int NR  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_ready;
    logic [NCH-1:0]    req_we;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH*DW-1:0] req_wdata;
    logic              resp_valid;
    logic [CHW-1:0]    resp_ch;
    logic [DW-1:0]     resp_rdata;
    logic              resp_err;
    logic              cfg_we;
    logic [RB-1:0]     cfg_region;
    logic [NCH-1:0]    cfg_rd_mask;
    logic [NCH-1:0]    cfg_wr_mask;
    logic [15:0]       deny_count;
    logic              busy;

    always #5 clk = ~clk;

    guarded_mem_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_CH     (NCH),
        .REGION_BITS(RB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ch    (resp_ch),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .cfg_we     (cfg_we),
        .cfg_region (cfg_region),
        .cfg_rd_mask(cfg_rd_mask),
        .cfg_wr_mask(cfg_wr_mask),
        .deny_count (deny_count),
        .busy       (busy)
    );

    // Outstanding request per channel; a channel keeps its request until granted.
    bit             pendV    [NCH];
    bit             pendWe   [NCH];
    logic [AW-1:0]  pendAddr [NCH];
    logic [DW-1:0]  pendData [NCH];
    int             refillMode;
    bit             onlyWrites;

    // Reference model state.
    logic [DW-1:0]  mMem [2**AW];
    logic [NCH-1:0] mRd  [NR];
    logic [NCH-1:0] mWr  [NR];
    int             mDeny;
    int             mLast;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int            ch;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            expErr;
        logic [DW-1:0] expData;
        int            expDeny;
    } vec_t;

    vec_t vecs [8];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic resetModel();
        for (int r = 0; r < NR; r++) begin
            mRd[r] = NCH'(1);
            mWr[r] = NCH'(1);
        end
        mDeny = 0;
        mLast = NCH - 1;
    endtask

    task automatic drivePending();
        for (int i = 0; i < NCH; i++) begin
            req_valid[i]           = pendV[i];
            req_we[i]              = pendWe[i];
            req_addr[i*AW +: AW]   = pendAddr[i];
            req_wdata[i*DW +: DW]  = pendData[i];
        end
    endtask

    task automatic newRequest(input int c);
        pendV[c]    = 1'b1;
        pendWe[c]   = onlyWrites ? 1'b1 : 1'($urandom_range(0, 1));
        pendAddr[c] = AW'($urandom);
        pendData[c] = $urandom;
    endtask

    task automatic setRequest(input int c, input bit we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d);
        pendV[c]    = 1'b1;
        pendWe[c]   = we;
        pendAddr[c] = a;
        pendData[c] = d;
    endtask

    task automatic clearPending();
        for (int i = 0; i < NCH; i++) begin
            pendV[i]    = 1'b0;
            pendWe[i]   = 1'b0;
            pendAddr[i] = '0;
            pendData[i] = '0;
        end
    endtask

    function automatic int modelWinner();
        for (int k = 1; k <= NCH; k++) begin
            int c;
            c = (mLast + k) % NCH;
            if (pendV[c]) return c;
        end
        return -1;
    endfunction

    task automatic doReset();
        reset_n     = 1'b0;
        cfg_we      = 1'b0;
        cfg_region  = '0;
        cfg_rd_mask = '0;
        cfg_wr_mask = '0;
        clearPending();
        drivePending();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        resetModel();
        #1;
    endtask

    task automatic idleCfg(input logic [RB-1:0] region, input logic [NCH-1:0] rd,
                           input logic [NCH-1:0] wr);
        cfg_we      = 1'b1;
        cfg_region  = region;
        cfg_rd_mask = rd;
        cfg_wr_mask = wr;
        @(posedge clk);
        mRd[region] = rd;
        mWr[region] = wr;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // One full arbitration round starting in IDLE at a falling edge. cfgEdge
    // selects which of the four rising edges (0 = handshake .. 3 = RESP exit)
    // also carries a table write; -1 means none.
    task automatic applyStimulus(input int cfgEdge, input logic [RB-1:0] cfgRegion,
                                 input logic [NCH-1:0] cfgRd, input logic [NCH-1:0] cfgWr,
                                 output int gotCh, output logic gotErr,
                                 output logic [DW-1:0] gotData, output int gotDeny);
        int             w;
        int             region;
        bit             we;
        bit             allowed;
        logic [AW-1:0]  a;
        logic [DW-1:0]  d;
        logic [DW-1:0]  expData;
        logic [NCH-1:0] expGrant;

        gotCh   = -1;
        gotErr  = 1'b0;
        gotData = '0;
        gotDeny = 0;
        allowed = 1'b0;
        expData = '0;
        drivePending();
        #1;
        w = modelWinner();
        if (w < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL stimulus: no request pending at %0t", $time);
            return;
        end
        expGrant    = '0;
        expGrant[w] = 1'b1;
        checkOutput("req_ready grant", req_ready, expGrant);
        checkOutput("busy idle", busy, 0);
        for (int i = 0; i < NCH; i++) if (req_ready[i]) gotCh = i;
        we = pendWe[w];
        a  = pendAddr[w];
        d  = pendData[w];

        for (int e = 0; e < 4; e++) begin
            cfg_we      = (e == cfgEdge);
            cfg_region  = cfgRegion;
            cfg_rd_mask = cfgRd;
            cfg_wr_mask = cfgWr;
            @(posedge clk);
            if (e == 0) begin
                mLast = w;
                if (refillMode == 2 || (refillMode == 1 && $urandom_range(0, 1) == 1))
                    newRequest(w);
                else
                    pendV[w] = 1'b0;
            end
            if (e == 1) begin
                region  = int'(a) >> (AW - RB);
                allowed = we ? mWr[region][w] : mRd[region][w];
            end
            if (e == cfgEdge) begin
                mRd[cfgRegion] = cfgRd;
                mWr[cfgRegion] = cfgWr;
            end
            if (e == 2) begin
                if (allowed && we) mMem[a] = d;
                if (!allowed && mDeny < 16'hFFFF) mDeny++;
                expData = (allowed && !we) ? mMem[a] : '0;
            end
            @(negedge clk);
            cfg_we = 1'b0;
            if (e == 0) begin
                drivePending();
                #1;
                checkOutput("busy after grant", busy, 1);
                checkOutput("req_ready while busy", req_ready, 0);
            end
            if (e == 1) checkOutput("resp_valid early", resp_valid, 0);
            if (e == 2) begin
                checkOutput("resp_valid", resp_valid, 1);
                checkOutput("resp_ch", resp_ch, w);
                checkOutput("resp_err", resp_err, !allowed);
                checkOutput("resp_rdata", resp_rdata, expData);
                checkOutput("deny_count", deny_count, mDeny);
                gotErr  = resp_err;
                gotData = resp_rdata;
                gotDeny = int'(deny_count);
            end
            if (e == 3) begin
                checkOutput("resp_valid late", resp_valid, 0);
                checkOutput("resp_rdata late", resp_rdata, 0);
                checkOutput("busy back idle", busy, 0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int            gotCh;
        logic          gotErr;
        logic [DW-1:0] gotData;
        int            gotDeny;
        int            rrExp [5];
        logic [DW-1:0] oldWord;

        vecs[0] = '{ch: 0, we: 1, addr: 8'h10, wdata: 32'hDEADBEEF, expErr: 0, expData: 32'h0,        expDeny: 0};
        vecs[1] = '{ch: 0, we: 0, addr: 8'h10, wdata: 32'h0,        expErr: 0, expData: 32'hDEADBEEF, expDeny: 0};
        vecs[2] = '{ch: 1, we: 1, addr: 8'h10, wdata: 32'h12345678, expErr: 1, expData: 32'h0,        expDeny: 1};
        vecs[3] = '{ch: 0, we: 0, addr: 8'h10, wdata: 32'h0,        expErr: 0, expData: 32'hDEADBEEF, expDeny: 1};
        vecs[4] = '{ch: 0, we: 1, addr: 8'h00, wdata: 32'hCAFEF00D, expErr: 0, expData: 32'h0,        expDeny: 1};
        vecs[5] = '{ch: 1, we: 1, addr: 8'hFF, wdata: 32'hAAAA5555, expErr: 1, expData: 32'h0,        expDeny: 2};
        vecs[6] = '{ch: 0, we: 0, addr: 8'h00, wdata: 32'h0,        expErr: 0, expData: 32'hCAFEF00D, expDeny: 2};
        vecs[7] = '{ch: 3, we: 0, addr: 8'h80, wdata: 32'h0,        expErr: 1, expData: 32'h0,        expDeny: 3};
        rrExp = '{0, 1, 2, 3, 0};

        refillMode = 0;
        onlyWrites = 1'b1;
        doReset();

        checkOutput("reset req_ready", req_ready, 0);
        checkOutput("reset resp_valid", resp_valid, 0);
        checkOutput("reset resp_ch", resp_ch, 0);
        checkOutput("reset resp_rdata", resp_rdata, 0);
        checkOutput("reset resp_err", resp_err, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset deny_count", deny_count, 0);

        for (int v = 0; v < 8; v++) begin
            clearPending();
            setRequest(vecs[v].ch, vecs[v].we, vecs[v].addr, vecs[v].wdata);
            applyStimulus(-1, '0, '0, '0, gotCh, gotErr, gotData, gotDeny);
            checkOutput($sformatf("vec%0d ch", v), gotCh, vecs[v].ch);
            checkOutput($sformatf("vec%0d err", v), gotErr, vecs[v].expErr);
            checkOutput($sformatf("vec%0d rdata", v), gotData, vecs[v].expData);
            checkOutput($sformatf("vec%0d deny", v), gotDeny, vecs[v].expDeny);
        end

        // All channels requesting back to back from reset.
        doReset();
        refillMode = 2;
        onlyWrites = 1'b1;
        for (int c = 0; c < NCH; c++) newRequest(c);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(-1, '0, '0, '0, gotCh, gotErr, gotData, gotDeny);
            checkOutput($sformatf("rr order %0d", k), gotCh, rrExp[k]);
        end
        clearPending();
        drivePending();

        // Fill every word through channel 0 so later reads have known data.
        refillMode = 0;
        for (int a = 0; a < 2**AW; a++) begin
            clearPending();
            setRequest(0, 1'b1, AW'(a), $urandom);
            applyStimulus(-1, '0, '0, '0, gotCh, gotErr, gotData, gotDeny);
        end

        // Table write landing on the CHECK edge of the affected access.
        clearPending();
        setRequest(1, 1'b1, 8'h40, 32'h5A5A0001);
        applyStimulus(1, 2'd1, 4'b0001, 4'b0010, gotCh, gotErr, gotData, gotDeny);
        checkOutput("cfg same-edge err", gotErr, 1);
        setRequest(1, 1'b1, 8'h40, 32'h5A5A0001);
        applyStimulus(-1, '0, '0, '0, gotCh, gotErr, gotData, gotDeny);
        checkOutput("cfg retry err", gotErr, 0);
        setRequest(0, 1'b0, 8'h40, 32'h0);
        applyStimulus(-1, '0, '0, '0, gotCh, gotErr, gotData, gotDeny);
        checkOutput("cfg readback", gotData, 32'h5A5A0001);
        setRequest(0, 1'b1, 8'h40, 32'h0BAD0BAD);
        applyStimulus(-1, '0, '0, '0, gotCh, gotErr, gotData, gotDeny);
        checkOutput("cfg ch0 write revoked", gotErr, 1);

        // Random traffic with occasional table writes on arbitrary edges.
        onlyWrites = 1'b0;
        refillMode = 1;
        clearPending();
        for (int n = 0; n < 300; n++) begin
            int cfgEdge;
            bit any;
            for (int c = 0; c < NCH; c++)
                if (!pendV[c] && $urandom_range(0, 9) < 3) newRequest(c);
            any = 1'b0;
            for (int c = 0; c < NCH; c++) any |= pendV[c];
            if (!any) newRequest(int'($urandom_range(0, NCH - 1)));
            cfgEdge = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
            applyStimulus(cfgEdge, RB'($urandom), NCH'($urandom), NCH'($urandom),
                          gotCh, gotErr, gotData, gotDeny);
        end

        // Reset while a write is in ACCESS.
        refillMode = 0;
        clearPending();
        drivePending();
        idleCfg(2'd0, 4'b1111, 4'b1111);
        oldWord = mMem[8'h20];
        setRequest(0, 1'b1, 8'h20, 32'h11111111);
        drivePending();
        #1;
        checkOutput("abort grant", req_ready, 4'b0001);
        @(posedge clk);
        @(negedge clk);
        clearPending();
        drivePending();
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort in access busy", busy, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("abort resp_valid", resp_valid, 0);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort deny_count", deny_count, 0);
        checkOutput("abort req_ready", req_ready, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        resetModel();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("abort no response", resp_valid, 0);
        end
        setRequest(1, 1'b0, 8'h00, 32'h0);
        applyStimulus(-1, '0, '0, '0, gotCh, gotErr, gotData, gotDeny);
        checkOutput("abort table restored", gotErr, 1);
        setRequest(0, 1'b0, 8'h20, 32'h0);
        applyStimulus(-1, '0, '0, '0, gotCh, gotErr, gotData, gotDeny);
        checkOutput("abort word unchanged", gotData, oldWord);

        // Preload the counter just below its ceiling, then keep denying.
        clearPending();
        drivePending();
        force dut.r_denyCount = 16'hFFFD;
        @(negedge clk);
        release dut.r_denyCount;
        mDeny = 16'hFFFD;
        @(negedge clk);
        checkOutput("deny preload", deny_count, 16'hFFFD);
        for (int k = 0; k < 4; k++) begin
            setRequest(2, 1'b1, 8'hC0, $urandom);
            applyStimulus(-1, '0, '0, '0, gotCh, gotErr, gotData, gotDeny);
        end
        checkOutput("deny saturated", deny_count, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
